// File: rtl/vote_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vote_session_ctrl
// Description : Election sequencer between the per-candidate button
//               debouncers and the vote logger / LED mode logic. Opens and
//               closes the election, enforces one authorised vote per voter,
//               rejects ambiguous multi-button presses, holds a post-vote
//               lockout and auto-scans the result display once closed.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   LOCKOUT_CYCLES  busy cycles after an accepted vote
//   AUTH_TIMEOUT    cycles an authorisation stays live without a vote
//   DWELL_CYCLES    cycles each candidate is shown during the result scan
// Build option:
//   MANUAL_SCAN_EN  when defined, a single-bit vote_valid pulse in CLOSED
//                   jumps the display to that candidate and restarts dwell
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   open_election       pulse, starts the election
//   close_election      pulse, ends the election
//   authorize           pulse, arms exactly one vote
//   vote_valid[3:0]     debounced vote pulses, bit i = candidate i+1
//   vote_accept[3:0]    one-hot, one-cycle pulse to the logger
//   logger_mode         0 = counting allowed, 1 = counting frozen
//   busy_led            high during the post-vote lockout
//   error_multi         pulse, two or more buttons pressed while armed
//   error_timeout       pulse, authorisation expired
//   phase[2:0]          current state encoding
//   display_en          high once the election is closed
//   display_sel[1:0]    candidate index shown on the display
//   total_votes[15:0]   accepted vote count, saturating
// ============================================================================
module vote_session_ctrl #(
    parameter int LOCKOUT_CYCLES = 10,
    parameter int AUTH_TIMEOUT   = 1000,
    parameter int DWELL_CYCLES   = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        open_election,
    input  logic        close_election,
    input  logic        authorize,
    input  logic [3:0]  vote_valid,
    output logic [3:0]  vote_accept,
    output logic        logger_mode,
    output logic        busy_led,
    output logic        error_multi,
    output logic        error_timeout,
    output logic [2:0]  phase,
    output logic        display_en,
    output logic [1:0]  display_sel,
    output logic [15:0] total_votes
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_AUTH = 3'd1,
        S_ARMED     = 3'd2,
        S_LOCKOUT   = 3'd3,
        S_CLOSED    = 3'd4
    } state_t;

    // Terminal counts of the shared 31-bit timer for each timed state.
    localparam logic [30:0] AUTH_LAST  = 31'(AUTH_TIMEOUT - 1);
    localparam logic [30:0] LOCK_LAST  = 31'(LOCKOUT_CYCLES - 1);
    localparam logic [30:0] DWELL_LAST = 31'(DWELL_CYCLES - 1);
    localparam logic [15:0] VOTES_MAX  = 16'hFFFF;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t      state_q,         state_d;
    logic [30:0] timer_q,         timer_d;
    logic        close_pend_q,    close_pend_d;
    logic [3:0]  vote_accept_q,   vote_accept_d;
    logic        logger_mode_q,   logger_mode_d;
    logic        busy_led_q,      busy_led_d;
    logic        error_multi_q,   error_multi_d;
    logic        error_timeout_q, error_timeout_d;
    logic        display_en_q,    display_en_d;
    logic [1:0]  display_sel_q,   display_sel_d;
    logic [15:0] total_votes_q,   total_votes_d;

    // ------------------------------------------------------------------
    // Vote pattern classification
    // ------------------------------------------------------------------
    logic vote_single;
    logic vote_multi;

    always_comb begin
        // Exactly one bit set: non-zero and clearing the lowest set bit
        // leaves nothing behind.
        vote_single = (vote_valid != 4'b0000) &&
                      ((vote_valid & (vote_valid - 4'd1)) == 4'b0000);
        vote_multi  = (vote_valid != 4'b0000) && !vote_single;
    end

`ifdef MANUAL_SCAN_EN
    function automatic logic [1:0] onehot_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        case (v)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        close_pend_d    = close_pend_q;
        vote_accept_d   = 4'b0000;
        error_multi_d   = 1'b0;
        error_timeout_d = 1'b0;
        display_sel_d   = display_sel_q;
        total_votes_d   = total_votes_q;

        case (state_q)
            S_IDLE: begin
                if (open_election) begin
                    state_d = S_WAIT_AUTH;
                    timer_d = 31'd0;
                end
            end

            S_WAIT_AUTH: begin
                // Close wins over a same-cycle authorisation.
                if (close_election) begin
                    state_d       = S_CLOSED;
                    timer_d       = 31'd0;
                    display_sel_d = 2'd0;
                end else if (authorize) begin
                    state_d = S_ARMED;
                    timer_d = 31'd0;
                end
            end

            S_ARMED: begin
                timer_d = timer_q + 31'd1;
                if (close_election) begin
                    // Pending authorisation is voided; any same-cycle vote
                    // is dropped.
                    state_d       = S_CLOSED;
                    timer_d       = 31'd0;
                    display_sel_d = 2'd0;
                end else if (vote_single) begin
                    vote_accept_d = vote_valid;
                    if (total_votes_q != VOTES_MAX) begin
                        total_votes_d = total_votes_q + 16'd1;
                    end
                    state_d = S_LOCKOUT;
                    timer_d = 31'd0;
                end else if (vote_multi) begin
                    // Stay armed and keep counting toward the timeout.
                    error_multi_d = 1'b1;
                end else if (timer_q >= AUTH_LAST) begin
                    // ">=" rather than "==" so that a multi-press landing on
                    // the terminal cycle cannot leave the voter armed forever.
                    error_timeout_d = 1'b1;
                    state_d         = S_WAIT_AUTH;
                    timer_d         = 31'd0;
                end
            end

            S_LOCKOUT: begin
                if (close_election) begin
                    close_pend_d = 1'b1;
                end
                if (timer_q >= LOCK_LAST) begin
                    timer_d = 31'd0;
                    if (close_pend_q || close_election) begin
                        state_d       = S_CLOSED;
                        display_sel_d = 2'd0;
                        close_pend_d  = 1'b0;
                    end else begin
                        state_d = S_WAIT_AUTH;
                    end
                end else begin
                    timer_d = timer_q + 31'd1;
                end
            end

            S_CLOSED: begin
                if (timer_q >= DWELL_LAST) begin
                    display_sel_d = display_sel_q + 2'd1;
                    timer_d       = 31'd0;
                end else begin
                    timer_d = timer_q + 31'd1;
                end
`ifdef MANUAL_SCAN_EN
                // Manual selection overrides the auto-advance this cycle and
                // the scan then continues from the chosen candidate.
                if (vote_single) begin
                    display_sel_d = onehot_index(vote_valid);
                    timer_d       = 31'd0;
                end
`endif
            end

            default: begin
                state_d      = S_IDLE;
                timer_d      = 31'd0;
                close_pend_d = 1'b0;
            end
        endcase

        // Level outputs follow the state being entered so that they are
        // registered alongside it.
        logger_mode_d = (state_d == S_IDLE) || (state_d == S_CLOSED);
        busy_led_d    = (state_d == S_LOCKOUT);
        display_en_d  = (state_d == S_CLOSED);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            timer_q         <= 31'd0;
            close_pend_q    <= 1'b0;
            vote_accept_q   <= 4'b0000;
            logger_mode_q   <= 1'b1;
            busy_led_q      <= 1'b0;
            error_multi_q   <= 1'b0;
            error_timeout_q <= 1'b0;
            display_en_q    <= 1'b0;
            display_sel_q   <= 2'd0;
            total_votes_q   <= 16'd0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            close_pend_q    <= close_pend_d;
            vote_accept_q   <= vote_accept_d;
            logger_mode_q   <= logger_mode_d;
            busy_led_q      <= busy_led_d;
            error_multi_q   <= error_multi_d;
            error_timeout_q <= error_timeout_d;
            display_en_q    <= display_en_d;
            display_sel_q   <= display_sel_d;
            total_votes_q   <= total_votes_d;
        end
    end

    assign vote_accept   = vote_accept_q;
    assign logger_mode   = logger_mode_q;
    assign busy_led      = busy_led_q;
    assign error_multi   = error_multi_q;
    assign error_timeout = error_timeout_q;
    assign phase         = state_q;
    assign display_en    = display_en_q;
    assign display_sel   = display_sel_q;
    assign total_votes   = total_votes_q;

endmodule
`default_nettype wire

// File: tb/tb_vote_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vote_session_ctrl
// Description : Self-checking bench for vote_session_ctrl. Directed stimulus
//               in one initial block; accepted votes are predicted into a
//               scoreboard queue and checked by a negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vote_session_ctrl;

    localparam int LOCKOUT_CYCLES = 10;
    localparam int AUTH_TIMEOUT   = 1000;
    localparam int DWELL_CYCLES   = 4;

    logic        clock;
    logic        reset;
    logic        open_election;
    logic        close_election;
    logic        authorize;
    logic [3:0]  vote_valid;
    logic [3:0]  vote_accept;
    logic        logger_mode;
    logic        busy_led;
    logic        error_multi;
    logic        error_timeout;
    logic [2:0]  phase;
    logic        display_en;
    logic [1:0]  display_sel;
    logic [15:0] total_votes;

    vote_session_ctrl #(
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .AUTH_TIMEOUT   (AUTH_TIMEOUT),
        .DWELL_CYCLES   (DWELL_CYCLES)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .open_election  (open_election),
        .close_election (close_election),
        .authorize      (authorize),
        .vote_valid     (vote_valid),
        .vote_accept    (vote_accept),
        .logger_mode    (logger_mode),
        .busy_led       (busy_led),
        .error_multi    (error_multi),
        .error_timeout  (error_timeout),
        .phase          (phase),
        .display_en     (display_en),
        .display_sel    (display_sel),
        .total_votes    (total_votes)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_compared = 0;
    int n_failed   = 0;
    int cyc_cnt    = 0;

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [3:0] val;
        int         due;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Predict an accept for a vote driven now; it must appear right after
    // the next rising edge.
    task automatic expect_accept(input logic [3:0] v);
        exp_t e;
        e.val = v;
        e.due = cyc_cnt + 1;
        sb_q.push_back(e);
    endtask

    // Every non-zero vote_accept must match the head of the scoreboard,
    // both in value and in the cycle it appears.
    always @(negedge clock) begin
        if (vote_accept !== 4'b0000) begin
            exp_t e;
            n_compared++;
            if (sb_q.size() == 0) begin
                assert (vote_accept === 4'b0000) else begin
                    n_failed++;
                    $error("FAIL unexpected_accept: observed %b expected 0000", vote_accept);
                end
            end else begin
                e = sb_q.pop_front();
                assert ((vote_accept === e.val) && (cyc_cnt == e.due)) else begin
                    n_failed++;
                    $error("FAIL accept: observed %b@%0d expected %b@%0d",
                           vote_accept, cyc_cnt, e.val, e.due);
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clock);
    endtask

    initial begin
        reset          = 1'b1;
        open_election  = 1'b0;
        close_election = 1'b0;
        authorize      = 1'b0;
        vote_valid     = 4'b0000;
        repeat (3) cyc();

        // Reset state
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_logger_mode", 32'(logger_mode), 32'd1);
        chk("rst_busy", 32'(busy_led), 32'd0);
        chk("rst_display_en", 32'(display_en), 32'd0);
        chk("rst_display_sel", 32'(display_sel), 32'd0);
        chk("rst_total", 32'(total_votes), 32'd0);
        chk("rst_errors", {30'd0, error_multi, error_timeout}, 32'd0);
        reset = 1'b0;
        cyc();

        // Votes in IDLE are ignored
        vote_valid = 4'b0100; cyc(); vote_valid = 4'b0000;
        chk("idle_phase", 32'(phase), 32'd0);
        chk("idle_err", 32'(error_multi), 32'd0);
        chk("idle_total", 32'(total_votes), 32'd0);

        open_election = 1'b1; cyc(); open_election = 1'b0;
        chk("open_phase", 32'(phase), 32'd1);
        chk("open_logger_mode", 32'(logger_mode), 32'd0);

        // Votes in WAIT_AUTH are ignored, even multi-press
        vote_valid = 4'b1111; cyc(); vote_valid = 4'b0000;
        chk("wait_err", 32'(error_multi), 32'd0);
        chk("wait_phase", 32'(phase), 32'd1);
        chk("wait_total", 32'(total_votes), 32'd0);

        // Single legal vote and lockout
        authorize = 1'b1; cyc(); authorize = 1'b0;
        chk("auth_phase", 32'(phase), 32'd2);
        vote_valid = 4'b0100; expect_accept(4'b0100); cyc(); vote_valid = 4'b0000;
        chk("vote1_phase", 32'(phase), 32'd3);
        chk("vote1_busy", 32'(busy_led), 32'd1);
        chk("vote1_total", 32'(total_votes), 32'd1);
        authorize = 1'b1; cyc(); authorize = 1'b0;   // ignored during lockout
        repeat (8) cyc();
        chk("busy_last", 32'(busy_led), 32'd1);
        cyc();
        chk("busy_fall", 32'(busy_led), 32'd0);
        chk("lock_end_phase", 32'(phase), 32'd1);

        // Multi-press then legal vote
        authorize = 1'b1; cyc(); authorize = 1'b0;
        vote_valid = 4'b0011; cyc(); vote_valid = 4'b0000;
        chk("multi_err", 32'(error_multi), 32'd1);
        chk("multi_phase", 32'(phase), 32'd2);
        cyc();
        chk("multi_err_width", 32'(error_multi), 32'd0);
        vote_valid = 4'b0001; expect_accept(4'b0001); cyc(); vote_valid = 4'b0000;
        chk("vote2_phase", 32'(phase), 32'd3);
        chk("vote2_total", 32'(total_votes), 32'd2);
        repeat (LOCKOUT_CYCLES) cyc();
        chk("vote2_back_phase", 32'(phase), 32'd1);

        // Authorisation timeout
        authorize = 1'b1; cyc(); authorize = 1'b0;
        repeat (AUTH_TIMEOUT - 1) cyc();
        chk("to_early_err", 32'(error_timeout), 32'd0);
        chk("to_early_phase", 32'(phase), 32'd2);
        cyc();
        chk("to_err", 32'(error_timeout), 32'd1);
        chk("to_phase", 32'(phase), 32'd1);
        chk("to_total", 32'(total_votes), 32'd2);
        cyc();
        chk("to_err_width", 32'(error_timeout), 32'd0);

        // Close latched during lockout
        authorize = 1'b1; cyc(); authorize = 1'b0;
        vote_valid = 4'b1000; expect_accept(4'b1000); cyc(); vote_valid = 4'b0000;
        chk("vote3_total", 32'(total_votes), 32'd3);
        close_election = 1'b1; cyc(); close_election = 1'b0;
        repeat (LOCKOUT_CYCLES - 2) cyc();
        chk("close_lock_phase", 32'(phase), 32'd3);
        cyc();
        chk("close_phase", 32'(phase), 32'd4);
        chk("close_display_en", 32'(display_en), 32'd1);
        chk("close_logger_mode", 32'(logger_mode), 32'd1);
        chk("close_busy", 32'(busy_led), 32'd0);

        // Automatic result scan
        for (int k = 0; k < 5 * DWELL_CYCLES; k++) begin
            chk("scan_sel", 32'(display_sel), 32'((k / DWELL_CYCLES) % 4));
            cyc();
        end

        // Vote and open in CLOSED: no accept, no state change
        vote_valid = 4'b0100; open_election = 1'b1; cyc();
        vote_valid = 4'b0000; open_election = 1'b0;
        chk("closed_phase", 32'(phase), 32'd4);
        chk("closed_total", 32'(total_votes), 32'd3);
        chk("closed_err", 32'(error_multi), 32'd0);
`ifdef MANUAL_SCAN_EN
        chk("manual_sel", 32'(display_sel), 32'd2);
        repeat (DWELL_CYCLES - 1) cyc();
        chk("manual_hold", 32'(display_sel), 32'd2);
        cyc();
        chk("manual_adv", 32'(display_sel), 32'd3);
`else
        chk("closed_sel", 32'(display_sel), 32'd1);
        repeat (DWELL_CYCLES - 1) cyc();
        chk("closed_sel_adv", 32'(display_sel), 32'd2);
`endif

        // Mid-operation reset clears everything
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("rst2_phase", 32'(phase), 32'd0);
        chk("rst2_total", 32'(total_votes), 32'd0);
        chk("rst2_display_en", 32'(display_en), 32'd0);
        chk("rst2_logger_mode", 32'(logger_mode), 32'd1);

        // Close and vote in the same armed cycle: close wins, no accept
        open_election = 1'b1; cyc(); open_election = 1'b0;
        authorize = 1'b1; cyc(); authorize = 1'b0;
        chk("arm2_phase", 32'(phase), 32'd2);
        close_election = 1'b1; vote_valid = 4'b0010; cyc();
        close_election = 1'b0; vote_valid = 4'b0000;
        chk("cv_phase", 32'(phase), 32'd4);
        chk("cv_total", 32'(total_votes), 32'd0);
        chk("cv_sel", 32'(display_sel), 32'd0);
        repeat (3) cyc();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
`default_nettype wire
